// File: rtl/symbol_slicer_demapper.sv
// 4-ASK Gray slicer with block-averaged adaptive outer threshold and
// delayed-reference symbol error counting for SER/BER measurement.
module symbol_slicer_demapper #(
  parameter int                      WIDTH       = 18,
  parameter int                      LOG2_BLOCK  = 8,
  parameter logic signed [WIDTH-1:0] INIT_THRESH = 18'sd65536,
  parameter int                      REF_DELAY   = 4,
  parameter int                      CNT_WIDTH   = 16
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    sym_clk_ena,
  input  logic signed [WIDTH-1:0] decision_variable,
  input  logic [1:0]              ref_sym,
  input  logic                    clr_counts,
  output logic [1:0]              sym_out,
  output logic                    sym_valid,
  output logic [WIDTH-1:0]        threshold,
  output logic                    tracking,
  output logic [CNT_WIDTH-1:0]    sym_count,
  output logic [CNT_WIDTH-1:0]    err_count
);

  localparam int              AW       = WIDTH + LOG2_BLOCK;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       FILL_MAX = 4'(REF_DELAY);

  typedef enum logic {ACQUIRE = 1'b0, TRACK = 1'b1} state_t;

  state_t                 r_state;
  logic                   r_tracking;
  logic [WIDTH-1:0]       r_thresh;
  logic [AW-1:0]          r_acc;
  logic [LOG2_BLOCK-1:0]  r_blk;
  logic [1:0]             r_sym;
  logic                   r_valid;
  logic [3:0]             r_fill;
  logic [1:0]             r_ref [REF_DELAY];
  logic [CNT_WIDTH-1:0]   r_sym_cnt;
  logic [CNT_WIDTH-1:0]   r_err_cnt;

  logic [WIDTH-1:0]       w_x;
  logic [WIDTH-1:0]       w_abs;
  logic                   w_ge;
  logic [1:0]             w_slice;
  logic [AW-1:0]          w_acc_sum;
  logic                   w_blk_done;
  logic                   w_cmp;
  logic                   w_mis;

  // Most negative input cannot be negated in WIDTH bits, so clamp it.
  assign w_x = decision_variable;
  always_comb begin
    w_abs = w_x;
    if (w_x[WIDTH-1]) begin
      w_abs = (w_x == MIN_NEG) ? MAX_POS : (~w_x + ONE_W);
    end
  end

  assign w_ge       = (w_abs >= r_thresh);
  assign w_slice    = w_x[WIDTH-1] ? (w_ge ? 2'b00 : 2'b01) : (w_ge ? 2'b10 : 2'b11);
  assign w_acc_sum  = r_acc + {{LOG2_BLOCK{1'b0}}, w_abs};
  assign w_blk_done = &r_blk;
  assign w_cmp      = sym_clk_ena && (r_state == TRACK) && (r_fill == FILL_MAX);
  assign w_mis      = w_cmp && (r_ref[REF_DELAY-1] != w_slice);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sym   <= 2'b00;
      r_valid <= 1'b0;
    end else begin
      r_valid <= sym_clk_ena;
      if (sym_clk_ena) r_sym <= w_slice;
    end
  end

  // Threshold estimation and acquisition FSM; the completing strobe still
  // sliced against the old threshold above.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ACQUIRE;
      r_tracking <= 1'b0;
      r_thresh   <= INIT_THRESH;
      r_acc      <= '0;
      r_blk      <= '0;
    end else if (sym_clk_ena) begin
      r_blk <= r_blk + 1'b1;
      if (w_blk_done) begin
        r_thresh   <= w_acc_sum[AW-1:LOG2_BLOCK];
        r_acc      <= '0;
        r_state    <= TRACK;
        r_tracking <= 1'b1;
      end else begin
        r_acc <= w_acc_sum;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill   <= '0;
      r_ref[0] <= 2'b00;
    end else if (sym_clk_ena) begin
      r_ref[0] <= ref_sym;
      if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
    end
  end

  generate
    for (genvar gi = 1; gi < REF_DELAY; gi++) begin : g_ref_dly
      always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)         r_ref[gi] <= 2'b00;
        else if (sym_clk_ena) r_ref[gi] <= r_ref[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sym_cnt <= '0;
      r_err_cnt <= '0;
    end else if (clr_counts) begin
      r_sym_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_cmp && (r_sym_cnt != '1)) r_sym_cnt <= r_sym_cnt + 1'b1;
      if (w_mis && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign sym_out   = r_sym;
  assign sym_valid = r_valid;
  assign threshold = r_thresh;
  assign tracking  = r_tracking;
  assign sym_count = r_sym_cnt;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_symbol_slicer_demapper.sv
// Directed bench for symbol_slicer_demapper: slicing boundaries, threshold
// adaptation, delayed-reference error counting, saturation and reset.
module tb_symbol_slicer_demapper;

  logic               sys_clk = 1'b0;
  logic               reset_n;
  logic               sym_clk_ena;
  logic signed [17:0] decision_variable;
  logic [1:0]         ref_sym;
  logic               clr_counts;
  logic [1:0]         sym_out;
  logic               sym_valid;
  logic [17:0]        threshold;
  logic               tracking;
  logic [15:0]        sym_count;
  logic [15:0]        err_count;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  symbol_slicer_demapper dut (
    .sys_clk           (sys_clk),
    .reset_n           (reset_n),
    .sym_clk_ena       (sym_clk_ena),
    .decision_variable (decision_variable),
    .ref_sym           (ref_sym),
    .clr_counts        (clr_counts),
    .sym_out           (sym_out),
    .sym_valid         (sym_valid),
    .threshold         (threshold),
    .tracking          (tracking),
    .sym_count         (sym_count),
    .err_count         (err_count)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    #1;
    if (sym_valid) pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the strobe's result visible.
  task automatic step(input int x, input logic [1:0] r);
    logic [31:0] xv;
    xv = x;
    sym_clk_ena       = 1'b1;
    decision_variable = xv[17:0];
    ref_sym           = r;
    @(negedge sys_clk);
  endtask

  task automatic idle();
    sym_clk_ena = 1'b0;
    @(negedge sys_clk);
  endtask

  function automatic int xfor(input logic [1:0] s);
    case (s)
      2'b10:   return 50000;
      2'b11:   return 20000;
      2'b01:   return -20000;
      default: return -50000;
    endcase
  endfunction

  logic [1:0] seq [12];
  int         p0;

  initial begin
    seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b11, 2'b00};
    reset_n = 1'b0; sym_clk_ena = 1'b0; decision_variable = '0; ref_sym = 2'b00; clr_counts = 1'b0;
    repeat (3) @(negedge sys_clk);
    reset_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // 1: reset state, no strobes
    chk("rst_thresh", threshold, 32'd65536);
    chk("rst_sym_out", sym_out, 2'b00);
    chk("rst_tracking", tracking, 1'b0);
    chk("rst_sym_count", sym_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_no_pulse", pulses, 0);

    // 2: slicing against the initial threshold, including ties and most-negative input
    step(100000, 2'b00);  chk("s2_p100000", sym_out, 2'b10); chk("s2_valid0", sym_valid, 1'b1);
    step(30000, 2'b00);   chk("s2_p30000", sym_out, 2'b11);
    step(0, 2'b00);       chk("s2_zero", sym_out, 2'b11);
    step(-30000, 2'b00);  chk("s2_m30000", sym_out, 2'b01);
    step(-65536, 2'b00);  chk("s2_m65536_tie", sym_out, 2'b00);
    step(-131072, 2'b00); chk("s2_min_neg", sym_out, 2'b00); chk("s2_valid5", sym_valid, 1'b1);
    idle();
    chk("s2_valid_drop", sym_valid, 1'b0);
    chk("s2_pulse_count", pulses, 6);
    chk("s2_no_tracking", tracking, 1'b0);

    // 3: one full block of |x|=40000 starting from a clean reset
    reset_n = 1'b0; @(negedge sys_clk); reset_n = 1'b1; @(negedge sys_clk);
    for (int i = 0; i < 255; i++) step((i % 2 == 0) ? 40000 : -40000, (i % 2 == 0) ? 2'b11 : 2'b01);
    chk("s3_pre_thresh", threshold, 32'd65536);
    chk("s3_pre_tracking", tracking, 1'b0);
    step(-40000, 2'b01);
    chk("s3_old_thr_slice", sym_out, 2'b01);
    chk("s3_thresh", threshold, 32'd40000);
    chk("s3_tracking", tracking, 1'b1);
    step(39999, 2'b00); chk("s3_p39999", sym_out, 2'b11);
    step(40000, 2'b00); chk("s3_p40000", sym_out, 2'b10);
    chk("s3_sym_count", sym_count, 2);
    chk("s3_err_count", err_count, 1);

    // 4: delayed-reference comparison with one corrupted reference
    for (int p = 0; p < 4; p++) step(20000, (p == 2) ? 2'b10 : seq[p]);
    sym_clk_ena = 1'b0; clr_counts = 1'b1; @(negedge sys_clk); clr_counts = 1'b0;
    chk("s4_clr_sym", sym_count, 0);
    chk("s4_clr_err", err_count, 0);
    chk("s4_thr_kept", threshold, 32'd40000);
    chk("s4_trk_kept", tracking, 1'b1);
    for (int j = 0; j < 8; j++) begin
      step(xfor(seq[j]), seq[j+4]);
      chk($sformatf("s4_slice%0d", j), sym_out, seq[j]);
    end
    chk("s4_sym_count", sym_count, 8);
    chk("s4_err_count", err_count, 1);

    // 5: saturation, then clear wins over a same-cycle mismatch
    for (int i = 0; i < 65540; i++) step(100000, 2'b00);
    chk("s5_sym_sat", sym_count, 16'hFFFF);
    chk("s5_err_sat", err_count, 16'hFFFF);
    step(100000, 2'b00);
    chk("s5_err_hold", err_count, 16'hFFFF);
    chk("s5_thresh", threshold, 32'd100000);
    clr_counts = 1'b1; step(100000, 2'b00); clr_counts = 1'b0;
    chk("s5_clr_sym", sym_count, 0);
    chk("s5_clr_err", err_count, 0);

    // 6: reset in the middle of a block discards the partial accumulation
    for (int i = 0; i < 100; i++) step((i % 2 == 0) ? 20000 : -20000, 2'b00);
    idle();
    chk("s6_pre_count", sym_count, 100);
    reset_n = 1'b0; #1;
    chk("s6_rst_thresh", threshold, 32'd65536);
    chk("s6_rst_tracking", tracking, 1'b0);
    chk("s6_rst_sym_out", sym_out, 2'b00);
    chk("s6_rst_valid", sym_valid, 1'b0);
    chk("s6_rst_sym_count", sym_count, 0);
    chk("s6_rst_err_count", err_count, 0);
    @(negedge sys_clk); reset_n = 1'b1; @(negedge sys_clk);
    for (int i = 0; i < 255; i++) step((i % 2 == 0) ? 40000 : -40000, 2'b00);
    chk("s6_255_thresh", threshold, 32'd65536);
    chk("s6_255_tracking", tracking, 1'b0);
    step(-40000, 2'b00);
    chk("s6_256_thresh", threshold, 32'd40000);
    chk("s6_256_tracking", tracking, 1'b1);
    p0 = pulses;
    idle(); idle();
    chk("s6_idle_no_pulse", pulses, p0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
